// File: rtl/msg_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msg_schedule                                                 |
// | Description : SHA-256 message schedule. Loads one 512-bit padded block and |
// |               streams W[0..ROUNDS-1] with K[0..ROUNDS-1] over a            |
// |               valid/ready handshake, expanding through a 16-word window.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_Wi,
  output logic [31:0]  out_Ki,
  output logic [5:0]   out_round,
  output logic         out_last,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [5:0] c_LAST_ROUND = 6'(ROUNDS - 1);

  localparam logic [31:0] c_K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_w [0:15];
  logic [5:0]  r_round;
  logic [31:0] w_blk_word [0:15];
  logic [31:0] w_new_word;
  logic        w_load;
  logic        w_beat;
  logic        w_final_beat;

  function automatic logic [31:0] f_sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // W0 sits in the most significant word of the block
  for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
    assign w_blk_word[gi] = in_block[511 - 32*gi -: 32];
  end

  assign w_load       = (r_state == ST_IDLE) && in_valid;
  assign w_beat       = (r_state == ST_RUN) && out_ready;
  assign w_final_beat = w_beat && (r_round == c_LAST_ROUND);
  assign w_new_word   = f_sig1(r_w[14]) + r_w[9] + f_sig0(r_w[1]) + r_w[0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        out_valid = 1'b1;
        if (w_final_beat) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Window load on block accept; slide one word and expand on each accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      r_round <= '0;
    end else if (w_load) begin
      for (int i = 0; i < 16; i++) r_w[i] <= w_blk_word[i];
      r_round <= '0;
    end else if (w_beat) begin
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_new_word;
      // Leaving RUN parks the counter at zero rather than counting past the end
      r_round <= w_final_beat ? 6'd0 : r_round + 6'd1;
    end
  end

  // Output words come straight from registers; K is a ROM read indexed by the round register
  assign out_Wi    = r_w[0];
  assign out_Ki    = (r_state == ST_RUN) ? c_K_TABLE[r_round] : 32'd0;
  assign out_round = r_round;
  assign out_last  = (r_state == ST_RUN) && (r_round == c_LAST_ROUND);

endmodule
`default_nettype wire

// File: tb/tb_msg_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_msg_schedule                                              |
// | Description : Scoreboard bench for msg_schedule (ROUNDS=64 and ROUNDS=17). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_msg_schedule;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ROUNDS=64 instance
  logic         in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic [511:0] in_block;
  logic [31:0]  out_Wi, out_Ki;
  logic [5:0]   out_round;

  // ROUNDS=17 instance
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_done;
  logic [511:0] b_in_block;
  logic [31:0]  b_out_Wi, b_out_Ki;
  logic [5:0]   b_out_round;

  msg_schedule #(.ROUNDS(64)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_Wi(out_Wi), .out_Ki(out_Ki),
    .out_round(out_round), .out_last(out_last), .done(done)
  );

  msg_schedule #(.ROUNDS(17)) u_dut17 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_block(b_in_block),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_Wi(b_out_Wi), .out_Ki(b_out_Ki),
    .out_round(b_out_round), .out_last(b_out_last), .done(b_done)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] k;
    logic [5:0]  rnd;
    logic        last;
  } exp_t;

  exp_t q64[$];
  exp_t q17[$];
  exp_t e64, e17;

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [511:0] blk_abc;
  logic [511:0] blk_pat;
  logic [511:0] blk_ones;
  logic [511:0] blk_other;

  // Golden model: full 64-entry schedule from the textbook recurrence
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] g_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] g_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_block(input logic [511:0] blk, input int rounds, input bit to17);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[511 - 32*t -: 32];
      else        w[t] = g_s1(w[t-2]) + w[t-7] + g_s0(w[t-15]) + w[t-16];
    end
    for (int t = 0; t < rounds; t++) begin
      e.w    = w[t];
      e.k    = k_tab[t];
      e.rnd  = 6'(t);
      e.last = (t == rounds - 1);
      if (to17) q17.push_back(e);
      else      q64.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stall-stability monitor for the ROUNDS=64 instance
  logic [31:0] p_w, p_k;
  logic [5:0]  p_r;
  logic        p_l;
  logic        p_stall = 1'b0;
  always @(negedge clk) begin
    if (p_stall && !rst) begin
      total++;
      if (out_valid !== 1'b1 || out_Wi !== p_w || out_Ki !== p_k || out_round !== p_r || out_last !== p_l) begin
        bad++;
        $display("FAIL stall_hold: got v=%b W=%h K=%h r=%0d l=%b, want v=1 W=%h K=%h r=%0d l=%b",
                 out_valid, out_Wi, out_Ki, out_round, out_last, p_w, p_k, p_r, p_l);
      end
    end
    p_stall = out_valid && !out_ready && !rst;
    p_w = out_Wi; p_k = out_Ki; p_r = out_round; p_l = out_last;
    if (out_valid && out_ready && !rst) begin
      total++;
      if (q64.size() == 0) begin
        bad++;
        $display("FAIL beat64_extra: got beat round=%0d W=%h, want no beat", out_round, out_Wi);
      end else begin
        e64 = q64.pop_front();
        if (out_Wi !== e64.w || out_Ki !== e64.k || out_round !== e64.rnd || out_last !== e64.last) begin
          bad++;
          $display("FAIL beat64: got W=%h K=%h r=%0d l=%b, want W=%h K=%h r=%0d l=%b",
                   out_Wi, out_Ki, out_round, out_last, e64.w, e64.k, e64.rnd, e64.last);
        end
      end
    end
  end

  // Scoreboard for the ROUNDS=17 instance
  always @(negedge clk) begin
    if (b_out_valid && b_out_ready && !rst) begin
      total++;
      if (q17.size() == 0) begin
        bad++;
        $display("FAIL beat17_extra: got beat round=%0d, want no beat", b_out_round);
      end else begin
        e17 = q17.pop_front();
        if (b_out_Wi !== e17.w || b_out_Ki !== e17.k || b_out_round !== e17.rnd || b_out_last !== e17.last) begin
          bad++;
          $display("FAIL beat17: got W=%h K=%h r=%0d l=%b, want W=%h K=%h r=%0d l=%b",
                   b_out_Wi, b_out_Ki, b_out_round, b_out_last, e17.w, e17.k, e17.rnd, e17.last);
        end
      end
    end
  end

  // Consume beats on the 64-round instance until done; measures, does not judge
  task automatic run_until_done(input int budget, input bit rnd, output int beats,
                                output bit seen, output bit last_ok);
    bit prev_last;
    prev_last = 1'b0;
    beats = 0; seen = 1'b0; last_ok = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen    = 1'b1;
        last_ok = prev_last && !out_valid && !in_ready;
      end else begin
        if (out_valid && out_ready) beats++;
        prev_last = out_valid && out_ready && out_last;
        @(posedge clk);
        #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_Wi !== 32'd0 || out_Ki !== 32'd0 ||
        out_round !== 6'd0 || out_last !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset64: got rdy=%b v=%b W=%h K=%h r=%0d l=%b d=%b, want 1 0 0 0 0 0 0",
               in_ready, out_valid, out_Wi, out_Ki, out_round, out_last, done);
    end
    total++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_Wi !== 32'd0 || b_out_Ki !== 32'd0 ||
        b_out_round !== 6'd0 || b_out_last !== 1'b0 || b_done !== 1'b0) begin
      bad++;
      $display("FAIL reset17: got rdy=%b v=%b W=%h K=%h r=%0d l=%b d=%b, want 1 0 0 0 0 0 0",
               b_in_ready, b_out_valid, b_out_Wi, b_out_Ki, b_out_round, b_out_last, b_done);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_abc();
    int beats; bit seen, last_ok;
    out_ready = 1'b0;
    step(); in_block = blk_abc; in_valid = 1'b1; push_block(blk_abc, 64, 0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_Wi !== 32'h61626380 || out_Ki !== 32'h428a2f98 || out_round !== 6'd0) begin
      bad++;
      $display("FAIL abc_first: got v=%b W=%h K=%h r=%0d, want v=1 W=61626380 K=428a2f98 r=0",
               out_valid, out_Wi, out_Ki, out_round);
    end
    run_until_done(300, 0, beats, seen, last_ok);
    total++;
    if (!seen || beats != 64 || !last_ok) begin
      bad++;
      $display("FAIL abc_count: got done=%b beats=%0d last_then_done=%b, want 1 64 1", seen, beats, last_ok);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || in_ready !== 1'b1 || q64.size() != 0) begin
      bad++;
      $display("FAIL abc_after: got done=%b rdy=%b pending=%0d, want 0 1 0", done, in_ready, q64.size());
    end
  endtask

  task automatic test_abc_spot_words();
    int seen_cnt;
    seen_cnt = 0;
    out_ready = 1'b1;
    step(); in_block = blk_abc; in_valid = 1'b1; push_block(blk_abc, 64, 0);
    step(); in_valid = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (out_valid && (out_round == 6'd16 || out_round == 6'd17 || out_round == 6'd63)) begin
        seen_cnt++;
        total++;
        if ((out_round == 6'd16 && out_Wi !== 32'h61626380) ||
            (out_round == 6'd17 && out_Wi !== 32'h000f0000) ||
            (out_round == 6'd63 && (out_Ki !== 32'hc67178f2 || out_last !== 1'b1))) begin
          bad++;
          $display("FAIL abc_known: got r=%0d W=%h K=%h l=%b, want W16=61626380 W17=000f0000 K63=c67178f2 l63=1",
                   out_round, out_Wi, out_Ki, out_last);
        end
      end
    end
    total++;
    if (seen_cnt != 3) begin
      bad++;
      $display("FAIL abc_known_seen: got %0d spot words, want 3", seen_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int beats; bit seen, last_ok;
    out_ready = 1'b0;
    step(); in_block = blk_abc; in_valid = 1'b1; push_block(blk_abc, 64, 0);
    step(); in_valid = 1'b0;
    run_until_done(2000, 1, beats, seen, last_ok);
    total++;
    if (!seen || beats != 64 || !last_ok || q64.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got done=%b beats=%0d last_then_done=%b pending=%0d, want 1 64 1 0",
               seen, beats, last_ok, q64.size());
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_in_valid();
    int beats; bit seen, last_ok; int busy_hi;
    busy_hi = 0;
    out_ready = 1'b1;
    step(); in_block = blk_abc; in_valid = 1'b1; push_block(blk_abc, 64, 0);
    step(); in_block = blk_other;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) busy_hi++;
      step();
    end
    in_valid = 1'b0;
    total++;
    if (busy_hi != 0) begin
      bad++;
      $display("FAIL ign_ready: got in_ready high %0d cycles in RUN, want 0", busy_hi);
    end
    run_until_done(300, 0, beats, seen, last_ok);
    total++;
    if (!seen || beats != 54 || !last_ok || q64.size() != 0) begin
      bad++;
      $display("FAIL ign_count: got done=%b beats=%0d last_then_done=%b pending=%0d, want 1 54 1 0",
               seen, beats, last_ok, q64.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int beats; bit seen, last_ok; int done_hi;
    done_hi = 0;
    out_ready = 1'b1;
    step(); in_block = blk_abc; in_valid = 1'b1; push_block(blk_abc, 64, 0);
    step(); in_valid = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (out_round !== 6'd20 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_at20: got r=%0d v=%b, want r=20 v=1", out_round, out_valid);
    end
    step();
    rst = 1'b0;
    q64.delete();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_round !== 6'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: got v=%b rdy=%b r=%0d d=%b, want 0 1 0 0", out_valid, in_ready, out_round, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0) done_hi++;
    end
    total++;
    if (done_hi != 0) begin
      bad++;
      $display("FAIL rst_nodone: got done high %0d cycles, want 0", done_hi);
    end
    step(); in_block = blk_pat; in_valid = 1'b1; push_block(blk_pat, 64, 0);
    step(); in_valid = 1'b0;
    run_until_done(300, 0, beats, seen, last_ok);
    total++;
    if (!seen || beats != 64 || !last_ok || q64.size() != 0) begin
      bad++;
      $display("FAIL rst_rerun: got done=%b beats=%0d last_then_done=%b pending=%0d, want 1 64 1 0",
               seen, beats, last_ok, q64.size());
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int beats; bit seen, last_ok;
    out_ready = 1'b1;
    step(); in_block = blk_pat; in_valid = 1'b1;
    push_block(blk_pat, 64, 0);
    push_block(blk_ones, 64, 0);
    step(); in_block = blk_ones;
    run_until_done(300, 0, beats, seen, last_ok);
    total++;
    if (!seen || beats != 64 || !last_ok) begin
      bad++;
      $display("FAIL b2b_first: got done=%b beats=%0d last_then_done=%b, want 1 64 1", seen, beats, last_ok);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
    end
    step(); in_valid = 1'b0;
    run_until_done(300, 0, beats, seen, last_ok);
    total++;
    if (!seen || beats != 64 || !last_ok || q64.size() != 0) begin
      bad++;
      $display("FAIL b2b_second: got done=%b beats=%0d last_then_done=%b pending=%0d, want 1 64 1 0",
               seen, beats, last_ok, q64.size());
    end
    @(negedge clk);
  endtask

  task automatic test_rounds17();
    int beats; bit seen, prev_last, last_ok;
    beats = 0; seen = 1'b0; prev_last = 1'b0; last_ok = 1'b0;
    b_out_ready = 1'b1;
    step(); b_in_block = blk_abc; b_in_valid = 1'b1; push_block(blk_abc, 17, 1);
    step(); b_in_valid = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (b_done) begin
        seen    = 1'b1;
        last_ok = prev_last && !b_out_valid && !b_in_ready;
      end else begin
        if (b_out_valid && b_out_ready) beats++;
        if (b_out_valid && b_out_last) begin
          total++;
          if (b_out_round !== 6'd16) begin
            bad++;
            $display("FAIL r17_last_round: got out_last at r=%0d, want r=16", b_out_round);
          end
        end
        prev_last = b_out_valid && b_out_last;
      end
    end
    total++;
    if (!seen || beats != 17 || !last_ok || q17.size() != 0) begin
      bad++;
      $display("FAIL r17_count: got done=%b beats=%0d last_then_done=%b pending=%0d, want 1 17 1 0",
               seen, beats, last_ok, q17.size());
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_block = '0;
    blk_abc = {32'h61626380, 448'd0, 32'h00000018};
    for (int i = 0; i < 16; i++) begin
      blk_pat[511 - 32*i -: 32]   = 32'ha5a50000 ^ (32'(i + 1) * 32'h01011011);
      blk_ones[511 - 32*i -: 32]  = 32'hffffffff;
      blk_other[511 - 32*i -: 32] = 32'hdead0000 + 32'(i);
    end

    test_reset();
    test_abc();
    test_abc_spot_words();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_mid();
    test_back_to_back();
    test_rounds17();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
